ts_cc_monitor: RTL and testbench

Continuity-counter monitor for one MPEG-2 TS byte stream, placed directly downstream of the sync recovery stage in each of the four channels. It consumes aligned 188-byte packets once sync is locked and parses the 4-byte header. It tracks the 4-bit continuity_counter per PID in a small table and flags continuity, transport-error-indicator and sync-loss events for the QoS counters.

---
 rtl/ts_cc_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_ts_cc_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ts_cc_monitor.sv
// Continuity-counter monitor for one aligned MPEG-2 TS stream: header parse, per-PID CC table, QoS flags.
// Optional TS_DISC_IND_EN: honour the adaptation-field discontinuity_indicator by skipping the CC check.
module ts_cc_monitor #(
  parameter int NUM_PIDS = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             sync_lock,
  input  logic             cnt_clr,
  output logic             pkt_done,
  output logic [12:0]      pid_out,
  output logic [3:0]       cc_out,
  output logic             cc_err,
  output logic             tei_err,
  output logic             table_full,
  output logic             sync_err,
  output logic [CNT_W-1:0] cc_err_count
);
  localparam int IDX_W = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

  typedef enum logic {HUNT, PKT} state_t;
  state_t state, state_next;
  logic [7:0] idx, idx_next;
  logic eval, sync_miss;

  logic        hdr_tei;
  logic [12:0] hdr_pid;
  logic [1:0]  hdr_afc;
  logic [3:0]  hdr_cc;

  logic [NUM_PIDS-1:0] tbl_valid;
  logic [12:0]         tbl_pid [NUM_PIDS];
  logic [3:0]          tbl_cc  [NUM_PIDS];
  logic [NUM_PIDS-1:0] tbl_dup;

  logic             hit, free;
  logic [IDX_W-1:0] hit_idx, free_idx, wr_idx;
  logic             is_null, disc_skip, err_c, full_c, wr_en, wr_dup;
  logic [3:0]       stored_cc, cc_inc;
  logic             stored_dup;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Loss of lock overrides everything, including a byte presented in the same cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    eval       = 1'b0;
    sync_miss  = 1'b0;
    if (!sync_lock) begin
      state_next = HUNT;
      idx_next   = '0;
    end else if (byte_valid) begin
      case (state)
        HUNT: if (byte_in == 8'h47) begin
          state_next = PKT;
          idx_next   = 8'd1;
        end
        PKT: if (idx == 8'd0) begin
          if (byte_in == 8'h47) idx_next = 8'd1;
          else begin
            sync_miss  = 1'b1;
            state_next = HUNT;
          end
        end else if (idx == 8'd187) begin
          eval     = 1'b1;
          idx_next = '0;
        end else begin
          idx_next = idx + 8'd1;
        end
        default: state_next = HUNT;
      endcase
    end
  end

`ifdef TS_DISC_IND_EN
  logic hdr_aflen_nz, hdr_disc;
  assign disc_skip = hdr_afc[1] && hdr_aflen_nz && hdr_disc;
`else
  assign disc_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_tei <= 1'b0;
      hdr_pid <= '0;
      hdr_afc <= '0;
      hdr_cc  <= '0;
`ifdef TS_DISC_IND_EN
      hdr_aflen_nz <= 1'b0;
      hdr_disc     <= 1'b0;
`endif
    end else if (state == PKT && byte_valid && sync_lock) begin
      case (idx)
        8'd1: begin
          hdr_tei       <= byte_in[7];
          hdr_pid[12:8] <= byte_in[4:0];
        end
        8'd2: hdr_pid[7:0] <= byte_in;
        8'd3: begin
          hdr_afc <= byte_in[5:4];
          hdr_cc  <= byte_in[3:0];
        end
`ifdef TS_DISC_IND_EN
        8'd4: hdr_aflen_nz <= (byte_in != 8'd0);
        8'd5: hdr_disc     <= byte_in[7];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_PIDS; i++) begin
      if (tbl_valid[i] && tbl_pid[i] == hdr_pid && !hit) begin
        hit     = 1'b1;
        hit_idx = i[IDX_W-1:0];
      end
      if (!tbl_valid[i] && !free) begin
        free     = 1'b1;
        free_idx = i[IDX_W-1:0];
      end
    end
  end

  assign is_null    = (hdr_pid == 13'h1FFF);
  assign stored_cc  = tbl_cc[hit_idx];
  assign stored_dup = tbl_dup[hit_idx];
  assign cc_inc     = stored_cc + 4'd1;

  // Every check on a tracked PID rewrites its CC so the monitor resynchronises after an error.
  always_comb begin
    err_c  = 1'b0;
    full_c = 1'b0;
    wr_en  = 1'b0;
    wr_idx = hit_idx;
    wr_dup = stored_dup;
    if (!is_null) begin
      if (hit) begin
        wr_en = 1'b1;
        if (disc_skip) wr_dup = 1'b0;
        else if (!hdr_afc[0]) err_c = (hdr_cc != stored_cc);
        else if (hdr_cc == cc_inc) wr_dup = 1'b0;
        else if (hdr_cc == stored_cc && !stored_dup) wr_dup = 1'b1;
        else begin
          err_c  = 1'b1;
          wr_dup = 1'b0;
        end
      end else if (free) begin
        wr_en  = 1'b1;
        wr_idx = free_idx;
        wr_dup = 1'b0;
      end else begin
        full_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_done     <= 1'b0;
      pid_out      <= '0;
      cc_out       <= '0;
      cc_err       <= 1'b0;
      tei_err      <= 1'b0;
      table_full   <= 1'b0;
      sync_err     <= 1'b0;
      cc_err_count <= '0;
      tbl_valid    <= '0;
      tbl_dup      <= '0;
      for (int unsigned i = 0; i < NUM_PIDS; i++) begin
        tbl_pid[i] <= '0;
        tbl_cc[i]  <= '0;
      end
    end else begin
      pkt_done   <= eval;
      cc_err     <= eval && err_c;
      tei_err    <= eval && !is_null && hdr_tei;
      table_full <= eval && full_c;
      sync_err   <= sync_miss;
      if (eval) begin
        pid_out <= hdr_pid;
        cc_out  <= hdr_cc;
      end
      if (cnt_clr) cc_err_count <= '0;
      else if (eval && err_c && cc_err_count != '1) cc_err_count <= cc_err_count + 1'b1;
      if (eval && wr_en) begin
        for (int unsigned i = 0; i < NUM_PIDS; i++) begin
          if (i[IDX_W-1:0] == wr_idx) begin
            tbl_valid[i] <= 1'b1;
            tbl_pid[i]   <= hdr_pid;
            tbl_cc[i]    <= hdr_cc;
            tbl_dup[i]   <= wr_dup;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed scoreboard bench for ts_cc_monitor (2-entry table, 2-bit saturating counter).
module tb_ts_cc_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        sync_lock = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        pkt_done, cc_err, tei_err, table_full, sync_err;
  logic [12:0] pid_out;
  logic [3:0]  cc_out;
  logic [1:0]  cc_err_count;

  ts_cc_monitor #(.NUM_PIDS(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .sync_lock(sync_lock), .cnt_clr(cnt_clr), .pkt_done(pkt_done),
    .pid_out(pid_out), .cc_out(cc_out), .cc_err(cc_err), .tei_err(tei_err),
    .table_full(table_full), .sync_err(sync_err), .cc_err_count(cc_err_count)
  );

  always #5 clk = ~clk;

`ifdef TS_DISC_IND_EN
  localparam logic DISC_ERR = 1'b0;
`else
  localparam logic DISC_ERR = 1'b1;
`endif

  typedef struct packed {
    logic [12:0] pid;
    logic [3:0]  cc;
    logic        err;
    logic        tei;
    logic        tf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   sync_seen = 0;
  logic stall_en = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (pkt_done === 1'b1) begin
      check("pkt_expected", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pid_out", 16'(pid_out), 16'(e.pid));
        check("cc_out", 16'(cc_out), 16'(e.cc));
        check("cc_err", 16'(cc_err), 16'(e.err));
        check("tei_err", 16'(tei_err), 16'(e.tei));
        check("table_full", 16'(table_full), 16'(e.tf));
      end
    end
    if (sync_err === 1'b1) sync_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    if (stall_en && $urandom_range(0, 5) == 0) begin
      byte_valid = 1'b0;
      tick();
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  // len < 188 sends a truncated packet and expects no result for it
  task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [1:0] afc,
                          input logic tei, input logic disc, input logic err, input logic tf,
                          input int len = 188);
    logic [7:0] b;
    if (len == 188) sb.push_back('{pid: pid, cc: cc, err: err, tei: tei, tf: tf});
    for (int i = 0; i < len; i++) begin
      case (i)
        0: b = 8'h47;
        1: b = {tei, 2'b00, pid[12:8]};
        2: b = pid[7:0];
        3: b = {2'b00, afc, cc};
        4: b = afc[1] ? 8'd1 : 8'($urandom);
        5: b = (afc[1] && disc) ? 8'h80 : 8'h00;
        default: b = 8'($urandom);
      endcase
      send_byte(b);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    sync_lock = 1'b1;
    do_reset();
    check("rst_pkt_done", 16'(pkt_done), 16'd0);
    check("rst_pid_out", 16'(pid_out), 16'd0);
    check("rst_cc_out", 16'(cc_out), 16'd0);
    check("rst_count", 16'(cc_err_count), 16'd0);
    check("rst_sync_err", 16'(sync_err), 16'd0);

    // Continuous CC 0..15,0 with random stalls
    stall_en = 1'b1;
    for (int i = 0; i < 17; i++) send_pkt(13'h100, 4'(i), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    stall_en = 1'b0;
    idle(3);
    check("count_clean", 16'(cc_err_count), 16'd0);

    // CC jump and counter saturation
    do_reset();
    send_pkt(13'h100, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h100, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h100, 4'd3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("count_one", 16'(cc_err_count), 16'd1);
    send_pkt(13'h100, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h100, 4'd7, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(13'h100, 4'd12, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(13'h100, 4'd1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("count_sat", 16'(cc_err_count), 16'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("count_clr", 16'(cc_err_count), 16'd0);

    // Reset mid-packet, duplicates, no-payload, TEI
    send_pkt(13'h300, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 50);
    do_reset();
    send_pkt(13'h200, 4'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h200, 4'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h200, 4'd5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(13'h201, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h201, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h201, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h201, 4'd7, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h200, 4'd6, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("count_dup", 16'(cc_err_count), 16'd1);

    // Table full and null PID
    do_reset();
    stall_en = 1'b1;
    send_pkt(13'h010, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h020, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h030, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      send_pkt(13'h030, 4'($urandom_range(0, 15)), 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pkt(13'h1FFF, 4'($urandom_range(0, 15)), 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h010, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    stall_en = 1'b0;
    idle(2);
    check("count_full", 16'(cc_err_count), 16'd0);

    // Sync loss at a boundary, lock drop mid-packet, relock with table intact
    send_pkt(13'h010, 4'd2, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00);
    check("sync_err_pulse", 16'(sync_err), 16'd1);
    idle(1);
    check("sync_err_clear", 16'(sync_err), 16'd0);
    repeat (3) send_byte(8'h00);
    send_pkt(13'h010, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h010, 4'd4, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    sync_lock = 1'b0;
    byte_in = 8'h47;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    sync_lock = 1'b1;
    tick();
    send_pkt(13'h010, 4'd9, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(13'h030, 4'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("count_relock", 16'(cc_err_count), 16'd1);
    check("sync_err_total", 16'(sync_seen), 16'd1);

    // Discontinuity indicator
    do_reset();
    send_pkt(13'h040, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h040, 4'd9, 2'b11, 1'b0, 1'b1, DISC_ERR, 1'b0);
    send_pkt(13'h040, 4'd10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("count_disc", 16'(cc_err_count), 16'(DISC_ERR));

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
